// File: rtl/data_player_pkg.sv
// data_player_pkg: register map, CTRL/STATUS bit positions, FSM states and INFO layout for data_player.
package data_player_pkg;

    localparam int REG_CTRL   = 0;
    localparam int REG_LEN    = 1;
    localparam int REG_WPTR   = 2;
    localparam int REG_WDATA  = 3;
    localparam int REG_STATUS = 4;
    localparam int REG_INFO   = 5;
    localparam int NUM_REGS   = 6;

    localparam int CTRL_START    = 0;
    localparam int CTRL_STOP     = 1;
    localparam int CTRL_LOOP     = 2;
    localparam int CTRL_WPTR_CLR = 3;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_ARMED    = 2;
    localparam int STAT_RPTR_LSB = 16;

    localparam int INFO_PORTS_LSB = 0;
    localparam int INFO_WIDTH_LSB = 8;
    localparam int INFO_DEPTH_LSB = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_PREFETCH, ST_PLAY, ST_ARMED} state_t;

    function automatic logic [31:0] info_word(input int np, input int dw, input int aw);
        return ((32'(np) & 32'hFF) << INFO_PORTS_LSB) |
               ((32'(dw) & 32'hFF) << INFO_WIDTH_LSB) |
               ((32'(aw) & 32'hFF) << INFO_DEPTH_LSB);
    endfunction

endpackage

// File: rtl/data_player_if.sv
// intbus_interf: word-addressed internal bus; writes take effect on the wr edge, rdata is registered one cycle after rd.
interface intbus_interf;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        wr;
    logic        rd;

    modport master (output addr, wdata, wr, rd, input rdata);
    modport slave  (input addr, wdata, wr, rd, output rdata);
endinterface

// File: rtl/data_player_ram.sv
// data_player_ram: simple dual-port sample buffer, bus-side write port and 1-cycle registered read port.
module data_player_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/data_player.sv
// data_player: CPU-loaded sample buffer streamed out on NUM_PORTS parallel lanes.
// Defining DATA_PLAYER_TRIGGER_EN adds a trig input and an ARMED state waiting for its rising edge.
module data_player
    import data_player_pkg::*;
#(
    parameter int BASEADDR   = 0,
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 1024
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            re,
`ifdef DATA_PLAYER_TRIGGER_EN
    input  logic                            trig,
`endif
    output logic [NUM_PORTS*DATA_WIDTH-1:0] data,
    output logic                            valid,
    output logic                            busy,
    intbus_interf.slave                     bus
);
    localparam int W  = NUM_PORTS * DATA_WIDTH;
    localparam int AW = $clog2(DATA_DEPTH);

    generate
        if (W > 32) begin : g_width_chk
            $error("data_player: NUM_PORTS*DATA_WIDTH exceeds 32");
        end
    endgenerate

    state_t        r_state, w_next;
    logic [AW:0]   r_len;
    logic [AW-1:0] r_wptr, r_rptr, w_next_rptr, w_raddr;
    logic          r_loop, r_done, r_valid;
    logic [W-1:0]  r_data, w_q;
    logic [31:0]   w_off, w_rd_val;
    logic          w_wr_ctrl, w_wr_len, w_wr_wptr, w_wr_wdata;
    logic          w_start, w_stop, w_go, w_accept, w_last, w_end, w_trig_rise;
    logic          w_unused;

    assign w_off      = bus.addr - 32'(BASEADDR);
    assign w_wr_ctrl  = bus.wr && w_off == REG_CTRL;
    assign w_wr_len   = bus.wr && w_off == REG_LEN;
    assign w_wr_wptr  = bus.wr && w_off == REG_WPTR;
    assign w_wr_wdata = bus.wr && w_off == REG_WDATA;
    assign w_stop     = w_wr_ctrl && bus.wdata[CTRL_STOP];
    assign w_start    = w_wr_ctrl && bus.wdata[CTRL_START] && !bus.wdata[CTRL_STOP];
    assign w_go       = w_start && r_len != '0;
    assign w_accept   = r_state == ST_PLAY && re && !w_start && !w_stop;
    // >= rather than == so a LEN shrunk below rptr still terminates on the next sample
    assign w_last      = {1'b0, r_rptr} + (AW+1)'(1) >= r_len;
    assign w_end       = w_accept && w_last && !r_loop;
    assign w_next_rptr = w_last ? '0 : r_rptr + 1'b1;
    // RAM always holds mem[rptr] ahead of the request, so a request is served on the next cycle
    assign w_raddr     = w_accept ? w_next_rptr : (r_state == ST_PLAY ? r_rptr : '0);
    assign data        = r_data;
    assign valid       = r_valid;
    assign busy        = r_state != ST_IDLE || r_valid;
    assign w_unused    = ^bus.wdata;

`ifdef DATA_PLAYER_TRIGGER_EN
    localparam state_t ST_GO = ST_ARMED;
    logic r_trig_d, r_trig_q;
    assign w_trig_rise = r_trig_d && !r_trig_q;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_trig_d <= 1'b0;
            r_trig_q <= 1'b0;
        end else begin
            r_trig_d <= trig;
            r_trig_q <= r_trig_d;
        end
    end
`else
    localparam state_t ST_GO = ST_PREFETCH;
    assign w_trig_rise = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ARMED:    w_next = w_trig_rise ? ST_PREFETCH : ST_ARMED;
            ST_PREFETCH: w_next = ST_PLAY;
            ST_PLAY:     w_next = w_end ? ST_IDLE : ST_PLAY;
            default:     w_next = ST_IDLE;
        endcase
        if (w_start) w_next = w_go ? ST_GO : ST_IDLE;
        if (w_stop) w_next = ST_IDLE;
    end

    assign w_rd_val = w_off == REG_CTRL   ? 32'(r_loop) << CTRL_LOOP :
                      w_off == REG_LEN    ? 32'(r_len) :
                      w_off == REG_WPTR   ? 32'(r_wptr) :
                      w_off == REG_STATUS ? (32'(r_rptr) << STAT_RPTR_LSB) |
                                            (32'(r_state == ST_ARMED) << STAT_ARMED) |
                                            (32'(r_done) << STAT_DONE) |
                                            (32'(busy) << STAT_BUSY) :
                      w_off == REG_INFO   ? info_word(NUM_PORTS, DATA_WIDTH, AW) : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_loop    <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            bus.rdata <= '0;
        end else begin
            r_state <= w_next;
            r_valid <= w_accept;
            if (w_accept) r_data <= w_q;
            if (w_go) r_rptr <= '0;
            else if (w_accept) r_rptr <= w_next_rptr;
            if (w_go) r_done <= 1'b0;
            else if (w_end || w_start) r_done <= 1'b1;
            if (w_wr_ctrl) r_loop <= bus.wdata[CTRL_LOOP];
            if (w_wr_len) r_len <= bus.wdata[AW:0];
            if (w_wr_wdata) r_wptr <= r_wptr + 1'b1;
            else if (w_wr_wptr) r_wptr <= bus.wdata[AW-1:0];
            else if (w_wr_ctrl && bus.wdata[CTRL_WPTR_CLR]) r_wptr <= '0;
            bus.rdata <= (bus.rd && w_off < NUM_REGS) ? w_rd_val : '0;
        end
    end

    data_player_ram #(.WIDTH(W), .DEPTH(DATA_DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .i_we    (w_wr_wdata),
        .i_waddr (r_wptr),
        .i_wdata (bus.wdata[W-1:0]),
        .i_raddr (w_raddr),
        .o_rdata (w_q)
    );
endmodule

// File: tb/tb_data_player.sv
// tb_data_player: directed-vector bench for data_player (default 2 lanes x 8 bits, depth 1024).
module tb_data_player;
    import data_player_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        re = 1'b0;
    logic [15:0] data;
    logic        valid, busy;
`ifdef DATA_PLAYER_TRIGGER_EN
    logic        trig = 1'b0;
`endif
    int n_vec = 0;
    int n_err = 0;

    intbus_interf bus();

    data_player dut (
        .clk    (clk),
        .resetn (resetn),
        .re     (re),
`ifdef DATA_PLAYER_TRIGGER_EN
        .trig   (trig),
`endif
        .data   (data),
        .valid  (valid),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.addr = 32'(a);
        bus.wdata = d;
        bus.wr = 1'b1;
        @(negedge clk);
        bus.wr = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        bus.addr = 32'(a);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        d = bus.rdata;
    endtask

    task automatic load(input logic [15:0] w[$]);
        wr(REG_CTRL, 32'h8);
        foreach (w[i]) wr(REG_WDATA, {16'h0, w[i]});
    endtask

    task automatic test_reset();
        logic [31:0] r;
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        step();
        n_vec++; if (data !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h want 0000", data); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        rd(REG_CTRL, r);
        n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", r); end
        rd(REG_LEN, r);
        n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL reset_len: got %h want 0", r); end
        rd(REG_WPTR, r);
        n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL reset_wptr: got %h want 0", r); end
        rd(REG_STATUS, r);
        n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want 0", r); end
        rd(REG_INFO, r);
        n_vec++; if (r !== 32'h000A0802) begin n_err++; $display("FAIL info: got %h want 000a0802", r); end
    endtask

    task automatic test_basic();
        logic [15:0] exp_d[3] = '{16'h0100, 16'h0302, 16'h0504};
        logic [31:0] r;
        load('{16'h0100, 16'h0302, 16'h0504});
        wr(REG_LEN, 32'd3);
        wr(REG_CTRL, 32'h1);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_prefetch: got %b want 1", busy); end
        step();
        re = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++; if (valid !== (i < 3)) begin n_err++; $display("FAIL basic_valid[%0d]: got %b want %b", i, valid, i < 3); end
            if (i < 3) begin
                n_vec++; if (data !== exp_d[i]) begin n_err++; $display("FAIL basic_data[%0d]: got %h want %h", i, data, exp_d[i]); end
            end
        end
        n_vec++; if (data !== 16'h0504) begin n_err++; $display("FAIL basic_hold: got %h want 0504", data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b want 0", busy); end
        re = 1'b0;
        rd(REG_STATUS, r);
        n_vec++; if (r !== 32'h2) begin n_err++; $display("FAIL basic_status: got %h want 00000002", r); end
    endtask

    task automatic test_gapped();
        logic [15:0] exp_d[4] = '{16'h1110, 16'h1312, 16'h1514, 16'h1716};
        logic pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] r;
        int k = 0;
        load('{16'h1110, 16'h1312, 16'h1514, 16'h1716});
        wr(REG_LEN, 32'd4);
        wr(REG_CTRL, 32'h1);
        step();
        for (int i = 0; i < 6; i++) begin
            re = pat[i];
            step();
            n_vec++; if (valid !== pat[i]) begin n_err++; $display("FAIL gap_valid[%0d]: got %b want %b", i, valid, pat[i]); end
            if (pat[i]) begin
                n_vec++; if (data !== exp_d[k]) begin n_err++; $display("FAIL gap_data[%0d]: got %h want %h", k, data, exp_d[k]); end
                k++;
            end
        end
        re = 1'b0;
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL gap_busy: got %b want 0", busy); end
        rd(REG_STATUS, r);
        n_vec++; if (r !== 32'h2) begin n_err++; $display("FAIL gap_status: got %h want 00000002", r); end
    endtask

    task automatic test_loop_stop();
        logic [15:0] exp_d[2] = '{16'hAA55, 16'h3CC3};
        logic [31:0] r;
        load('{16'hAA55, 16'h3CC3});
        wr(REG_LEN, 32'd2);
        wr(REG_CTRL, 32'h5);
        rd(REG_CTRL, r);
        n_vec++; if (r !== 32'h4) begin n_err++; $display("FAIL loop_ctrl_rd: got %h want 00000004", r); end
        re = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            n_vec++; if (valid !== 1'b1 || data !== exp_d[i % 2]) begin n_err++; $display("FAIL loop_data[%0d]: got %b/%h want 1/%h", i, valid, data, exp_d[i % 2]); end
        end
        wr(REG_CTRL, 32'h2);
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL stop_valid: got %b want 0", valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %b want 0", busy); end
        re = 1'b0;
        rd(REG_STATUS, r);
        n_vec++; if (r !== 32'h0001_0000) begin n_err++; $display("FAIL stop_status: got %h want 00010000", r); end
    endtask

    task automatic test_edges();
        logic [31:0] r;
        logic seen = 1'b0;
        wr(REG_LEN, 32'd0);
        wr(REG_CTRL, 32'h1);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL len0_busy: got %b want 0", busy); end
        re = 1'b1;
        repeat (3) begin step(); seen |= valid; end
        re = 1'b0;
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL len0_valid: got %b want 0", seen); end
        rd(REG_STATUS, r);
        n_vec++; if (r[1:0] !== 2'b10) begin n_err++; $display("FAIL len0_done: got %b want 10", r[1:0]); end
        wr(REG_LEN, 32'd3);
        wr(REG_CTRL, 32'h3);
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_stop_busy: got %b want 0", busy); end
        wr(REG_CTRL, 32'h1);
        step();
        re = 1'b1;
        step();
        n_vec++; if (data !== 16'hAA55) begin n_err++; $display("FAIL restart_pre0: got %h want aa55", data); end
        step();
        n_vec++; if (data !== 16'h3CC3) begin n_err++; $display("FAIL restart_pre1: got %h want 3cc3", data); end
        wr(REG_CTRL, 32'h1);
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL restart_gap0: got %b want 0", valid); end
        step();
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL restart_gap1: got %b want 0", valid); end
        step();
        n_vec++; if (valid !== 1'b1 || data !== 16'hAA55) begin n_err++; $display("FAIL restart_first: got %b/%h want 1/aa55", valid, data); end
        re = 1'b0;
        wr(REG_CTRL, 32'h2);
    endtask

    task automatic test_reset_wrap();
        logic [31:0] r;
        wr(REG_CTRL, 32'h1);
        step();
        re = 1'b1;
        repeat (2) step();
        resetn = 1'b0;
        step();
        n_vec++; if (data !== 16'h0 || valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midplay_reset: got %h/%b/%b want 0000/0/0", data, valid, busy); end
        resetn = 1'b1;
        re = 1'b0;
        rd(REG_LEN, r);
        n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL midplay_reset_len: got %h want 0", r); end
        wr(REG_CTRL, 32'h8);
        for (int i = 0; i <= 1024; i++) wr(REG_WDATA, 32'(i));
        rd(REG_WPTR, r);
        n_vec++; if (r !== 32'h1) begin n_err++; $display("FAIL wrap_wptr: got %h want 1", r); end
        rd(REG_WDATA, r);
        n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL wdata_rd: got %h want 0", r); end
        wr(REG_LEN, 32'd2);
        wr(REG_CTRL, 32'h1);
        step();
        re = 1'b1;
        step();
        n_vec++; if (data !== 16'h0400) begin n_err++; $display("FAIL wrap_mem0: got %h want 0400", data); end
        step();
        n_vec++; if (data !== 16'h0001) begin n_err++; $display("FAIL wrap_mem1: got %h want 0001", data); end
        re = 1'b0;
        step();
    endtask

`ifdef DATA_PLAYER_TRIGGER_EN
    task automatic test_trigger();
        logic [31:0] r;
        logic seen = 1'b0;
        wr(REG_CTRL, 32'h1);
        re = 1'b1;
        repeat (20) begin step(); seen |= valid; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL trig_wait_valid: got %b want 0", seen); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL trig_armed_busy: got %b want 1", busy); end
        rd(REG_STATUS, r);
        n_vec++; if (r[2] !== 1'b1) begin n_err++; $display("FAIL trig_armed_bit: got %b want 1", r[2]); end
        trig = 1'b1;
        step();
        trig = 1'b0;
        step();
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL trig_lat0: got %b want 0", valid); end
        step();
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL trig_lat1: got %b want 0", valid); end
        step();
        n_vec++; if (valid !== 1'b1 || data !== 16'h0400) begin n_err++; $display("FAIL trig_play: got %b/%h want 1/0400", valid, data); end
        re = 1'b0;
        wr(REG_CTRL, 32'h2);
    endtask
`endif

    initial begin
        bus.addr = '0;
        bus.wdata = '0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_loop_stop();
        test_edges();
        test_reset_wrap();
`ifdef DATA_PLAYER_TRIGGER_EN
        test_trigger();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/data_player.md
Name: data_player

Overview:
- Playback counterpart of data_collector: the CPU loads samples into an internal buffer over the internal bus, then the block streams them out on NUM_PORTS parallel lanes.
- Used as a pattern/stimulus source for DSP chains and for loopback tests against data_collector.
- Sits on intbus_interf at BASEADDR, in the same clock domain as the sample consumer.

Parameters:
- BASEADDR, 0, word address of register block on intbus_interf.
- NUM_PORTS, 2, number of output lanes.
- DATA_WIDTH, 8, bits per lane; NUM_PORTS*DATA_WIDTH must be ≤ 32, else elaboration $error.
- DATA_DEPTH, 1024, buffer depth in samples; power of 2.

Ports:
- clk  input  1  single clock for bus and playback.
- resetn  input  1  synchronous, active-low reset.
- re  input  1  sample request; one sample consumed per cycle with re=1 while playing.
- data  output  NUM_PORTS*DATA_WIDTH  output samples; lane i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- valid  output  1  data carries a new sample this cycle.
- busy  output  1  playback active.
- bus  interface  -  intbus_interf slave; read/write timing per the intbus_interf convention.

Behaviour:
- Register map (word offsets from BASEADDR):
  - 0 CTRL: b0 START (pulse), b1 STOP (pulse), b2 LOOP (level, readable), b3 WPTR_CLR (pulse).
  - 1 LEN: [log2(DEPTH):0], valid range 1..DATA_DEPTH.
  - 2 WPTR: R/W write pointer.
  - 3 WDATA: write stores mem[WPTR], then WPTR = (WPTR+1) mod DATA_DEPTH; reads return 0.
  - 4 STATUS (RO): b0 busy, b1 done, [31:16] rptr.
  - 5 INFO (RO): [7:0] NUM_PORTS, [15:8] DATA_WIDTH, [23:16] log2(DATA_DEPTH).
- Reset:
  - data=0, valid=0, busy=0, done=0.
  - LEN=0, LOOP=0, WPTR=0, rptr=0.
  - FSM returns to IDLE.
  - Buffer contents are not cleared.
- FSM states: IDLE, PREFETCH, PLAY.
  - IDLE --START & LEN≠0--> PREFETCH: rptr=0, done cleared.
  - PREFETCH --1 cycle--> PLAY: mem[0] read; busy=1 from PREFETCH onward.
  - PLAY --STOP--> IDLE: valid=0 next cycle; done not set.
  - PLAY, last sample accepted (rptr==LEN-1 & re & !LOOP) --> IDLE: done=1, busy=0 the cycle after that sample's valid.
  - PLAY with LOOP=1: rptr wraps LEN-1 → 0 and playback continues without a bubble.
- Latency:
  - START write in cycle N → PREFETCH in N+1, PLAY in N+2.
  - re=1 in PLAY cycle M → data/valid in M+1.
  - Back-to-back re yields consecutive samples with no bubbles.
- re outside PLAY is ignored. With re=0, valid=0 and data holds its last value.
- Boundary and simultaneous events:
  - START with LEN=0: no playback; done=1 next cycle.
  - START while busy: restart from rptr=0.
  - START and STOP in the same write: STOP wins; START is ignored.
  - WDATA write during playback: allowed (dual-port buffer). A sample written before the cycle in which it is read plays new data.
  - LEN written during playback: takes effect immediately. If rptr ≥ new LEN, the next accepted sample ends (or wraps) playback.
  - WPTR_CLR together with a WDATA write: clear first, then data goes to address 0.

Optional Feature:
- Macro: DATA_PLAYER_TRIGGER_EN.
- With macro defined:
  - Adds input port trig (1 bit) and FSM state ARMED.
  - START → ARMED (busy=1).
  - trig rising edge (registered, 1-cycle detect) → PREFETCH.
  - STOP in ARMED → IDLE.
  - STATUS b2 = armed.
- Without macro: no trig port; START goes directly to PREFETCH; STATUS b2 reads 0.

Decomposition:
- data_player_pkg holds:
  - register offsets;
  - CTRL/STATUS bit indices;
  - FSM state enum typedef;
  - INFO field layout.
- Sub-module data_player_ram: simple dual-port RAM.
  - Write port on the bus side.
  - Registered read, 1-cycle latency.
  - Width NUM_PORTS*DATA_WIDTH, depth DATA_DEPTH.

Test Plan:
- Basic playback: write WDATA 16'h0100,16'h0302,16'h0504 with LEN=3, START, re held high → valid for exactly 3 cycles; lane0 = 00,02,04; lane1 = 01,03,05; then done=1, busy=0.
- Gapped requests: LEN=4 with re pattern 1,0,1,1,0,1 → 4 valid pulses, each one cycle after its re, data in order; done after the 4th.
- Loop and stop: LOOP=1, LEN=2, re high for 7 cycles → sequence s0,s1,s0,s1,s0,s1,s0; STOP → valid=0 next cycle, done=0.
- Edge writes: START with LEN=0 → no valid, done=1. START+STOP in one write → stays IDLE. START mid-play → next sample is mem[0].
- Reset and pointer wrap: assert resetn=0 mid-play → all outputs 0 next edge. Write DATA_DEPTH+1 words → WPTR=1, mem[0] holds the last word.
- Trigger (DATA_PLAYER_TRIGGER_EN only): START, wait 20 cycles with trig=0 → no valid; trig pulse → PLAY two cycles after the edge is detected.
